// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl codes, ALUOp encodings and FSM state type shared by the ALU/MDU block
package alu_pkg;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_MUL   = 4'd10;
  localparam logic [3:0] ALU_MULHU = 4'd11;
  localparam logic [3:0] ALU_DIV   = 4'd12;
  localparam logic [3:0] ALU_DIVU  = 4'd13;
  localparam logic [3:0] ALU_REM   = 4'd14;
  localparam logic [3:0] ALU_REMU  = 4'd15;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/op/funct3/funct7 -> 4-bit ALUControl, M-extension gated by MDU_EN
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter bit MDU_EN = 1'b1
) (
  input  logic [1:0] ALUOp,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] ALUControl
);
  logic       m_op;
  logic [3:0] base, mext;
  logic       unused_op;
  assign unused_op = ^{op[6], op[4:0]};
  always_comb begin
    m_op = op[5] && funct7 == 7'b0000001;
    case (funct3)
      3'b000:  base = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  base = ALU_SLL;
      3'b010:  base = ALU_SLT;
      3'b011:  base = ALU_SLTU;
      3'b100:  base = ALU_XOR;
      3'b101:  base = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  base = ALU_OR;
      default: base = ALU_AND;
    endcase
    mext = funct3 == 3'b011 ? ALU_MULHU :
           funct3 == 3'b100 ? ALU_DIV :
           funct3 == 3'b101 ? ALU_DIVU :
           funct3 == 3'b110 ? ALU_REM :
           funct3 == 3'b111 ? ALU_REMU : ALU_MUL;
    ALUControl = ALUOp == ALUOP_SUB   ? ALU_SUB :
                 ALUOp != ALUOP_RTYPE ? ALU_ADD :
                 !m_op                ? base :
                 MDU_EN               ? mext : ALU_ADD;
  end
endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: valid/ready ALU with iterative shift-add MUL/MULHU and restoring DIV/REM; registered Result/Zero
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_e              state_q, state_d;
  logic [3:0]          ctl, ctl_q, ctl_d;
  logic [XLEN-1:0]     opr_q, opr_d, result_q, result_d, alu_y, res_new;
  logic [XLEN-1:0]     a_mag, b_mag, q_fix, r_fix;
  logic [2*XLEN-1:0]   acc_q, acc_d, mul_acc, div_acc;
  logic [XLEN:0]       mul_hi, div_r, div_t;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d, zero_q, zero_d, load;
  logic                is_mul, is_div, is_sdiv, is_rem, a_neg, b_neg, dz, ovf;
  alu_ctrl_decode #(.MDU_EN(MDU_EN)) u_dec (
    .ALUOp     (ALUOp),
    .op        (op),
    .funct3    (funct3),
    .funct7    (funct7),
    .ALUControl(ctl)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Result    = result_q;
  assign Zero      = zero_q;
  always_comb begin
    is_mul  = ctl == ALU_MUL || ctl == ALU_MULHU;
    is_div  = ctl inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    is_sdiv = ctl == ALU_DIV || ctl == ALU_REM;
    is_rem  = ctl == ALU_REM || ctl == ALU_REMU;
    a_neg   = is_sdiv & SrcA[XLEN-1];
    b_neg   = is_sdiv & SrcB[XLEN-1];
    a_mag   = a_neg ? -SrcA : SrcA;
    b_mag   = b_neg ? -SrcB : SrcB;
    dz      = SrcB == '0;
    ovf     = is_sdiv && SrcA == MIN_NEG && SrcB == '1;
    case (ctl)
      ALU_SUB:  alu_y = SrcA - SrcB;
      ALU_SLL:  alu_y = SrcA << SrcB[SW-1:0];
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      ALU_XOR:  alu_y = SrcA ^ SrcB;
      ALU_SRL:  alu_y = SrcA >> SrcB[SW-1:0];
      ALU_SRA:  alu_y = $unsigned($signed(SrcA) >>> SrcB[SW-1:0]);
      ALU_OR:   alu_y = SrcA | SrcB;
      ALU_AND:  alu_y = SrcA & SrcB;
      default:  alu_y = SrcA + SrcB;
    endcase
    mul_hi  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? opr_q : {XLEN{1'b0}}};
    mul_acc = {mul_hi, acc_q[XLEN-1:1]};
    div_r   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_t   = div_r - {1'b0, opr_q};
    div_acc = {div_t[XLEN] ? div_r[XLEN-1:0] : div_t[XLEN-1:0], acc_q[XLEN-2:0], ~div_t[XLEN]};
    q_fix   = neg_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
    r_fix   = neg_q ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];
    state_d = state_q;
    ctl_d   = ctl_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    load    = 1'b0;
    res_new = '0;
    case (state_q)
      IDLE: if (in_valid) begin
        ctl_d = ctl;
        cnt_d = CW'(XLEN);
        neg_d = is_rem ? a_neg : a_neg ^ b_neg;
        opr_d = is_mul ? SrcA : b_mag;
        acc_d = {{XLEN{1'b0}}, is_mul ? SrcB : a_mag};
        if (is_mul) state_d = MUL;
        else if (is_div && !dz && !ovf) state_d = DIV;
        else begin
          state_d = DONE;
          load    = 1'b1;
          res_new = !is_div ? alu_y : dz ? (is_rem ? SrcA : {XLEN{1'b1}}) : (is_rem ? {XLEN{1'b0}} : SrcA);
        end
      end
      MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          res_new = ctl_q == ALU_MULHU ? mul_acc[2*XLEN-1:XLEN] : mul_acc[XLEN-1:0];
        end
      end
      DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          load    = 1'b1;
          res_new = (ctl_q == ALU_REM || ctl_q == ALU_REMU) ? r_fix : q_fix;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    result_d = load ? res_new : result_q;
    zero_d   = load ? res_new == '0 : zero_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ctl_q    <= ALU_ADD;
      opr_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctl_q    <= ctl_d;
      opr_q    <= opr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed vectors with hand-computed results for the 32-bit and 8-bit ALU/MDU builds
module tb_alu_mdu_seq;
  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, Zero;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, Zero8;
  logic [1:0]  ALUOp;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB, Result;
  logic [7:0]  SrcA8, SrcB8, Result8;
  int          errs, checks;
  localparam logic [6:0] OPR = 7'h33, OPI = 7'h13, F7S = 7'h20, F7M = 7'h01;
  alu_mdu_seq #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .op(op), .funct3(funct3), .funct7(funct7),
    .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero)
  );
  alu_mdu_seq #(.XLEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .ALUOp(ALUOp), .op(op), .funct3(funct3), .funct7(funct7),
    .SrcA(SrcA8), .SrcB(SrcB8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Result(Result8), .Zero(Zero8)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] aop, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(negedge clk);
    ALUOp = aop; op = o; funct3 = f3; funct7 = f7; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] aop, input logic [6:0] o, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input int exp_lat);
    int lat;
    issue(aop, o, f3, f7, a, b, lat);
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, 64'(Result), 64'(exp_r));
    check({tag, ".zero"}, 64'(Zero), 64'(exp_r == 32'd0));
    pop();
  endtask
  task automatic run8(input string tag, input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_r, input int exp_lat);
    int lat;
    @(negedge clk);
    ALUOp = 2'b10; op = OPR; funct3 = f3; funct7 = F7M; SrcA8 = a; SrcB8 = b; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, 64'(Result8), 64'(exp_r));
    check({tag, ".zero"}, 64'(Zero8), 64'(exp_r == 8'd0));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
  endtask
  initial begin
    int lat, seen;
    logic [31:0] held;
    errs = 0; checks = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    ALUOp = 2'b00; op = OPR; funct3 = 3'b000; funct7 = 7'h00;
    SrcA = '0; SrcB = '0; SrcA8 = '0; SrcB8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(in_ready), 64'(1));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.result", 64'(Result), 64'(0));
    check("rst.zero", 64'(Zero), 64'(0));
    @(negedge clk) rst = 1'b1;
    run("sub",   2'b10, OPR, 3'b000, F7S, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
    run("sra",   2'b10, OPR, 3'b101, F7S, 32'h80000000, 32'd4, 32'hF8000000, 1);
    run("srl",   2'b10, OPR, 3'b101, 7'h00, 32'h80000000, 32'd4, 32'h08000000, 1);
    run("ld_add",2'b00, OPR, 3'b111, F7S, 32'd3, 32'd4, 32'd7, 1);
    run("br_sub",2'b01, OPR, 3'b000, 7'h00, 32'd9, 32'd9, 32'd0, 1);
    run("rsvd",  2'b11, OPR, 3'b100, F7M, 32'd10, 32'd20, 32'd30, 1);
    run("addi",  2'b10, OPI, 3'b000, F7S, 32'd5, 32'd7, 32'd12, 1);
    run("imul",  2'b10, OPI, 3'b000, F7M, 32'd3, 32'd4, 32'd7, 1);
    run("sll",   2'b10, OPR, 3'b001, 7'h00, 32'd1, 32'd33, 32'd2, 1);
    run("slt",   2'b10, OPR, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 1);
    run("sltu",  2'b10, OPR, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 1);
    run("xor",   2'b10, OPR, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run("or",    2'b10, OPR, 3'b110, 7'h00, 32'hF0F0F0F0, 32'h0000FF00, 32'hF0F0FFF0, 1);
    run("and",   2'b10, OPR, 3'b111, 7'h00, 32'hF0F0F0F0, 32'h0000FF00, 32'h0000F000, 1);
    run("mulhu", 2'b10, OPR, 3'b011, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mul",   2'b10, OPR, 3'b000, F7M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run("mul2",  2'b10, OPR, 3'b001, F7M, 32'd1234, 32'd5678, 32'd7006652, 33);
    run("div",   2'b10, OPR, 3'b100, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem",   2'b10, OPR, 3'b110, F7M, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu",  2'b10, OPR, 3'b101, F7M, 32'd100, 32'd7, 32'd14, 33);
    run("remu",  2'b10, OPR, 3'b111, F7M, 32'd100, 32'd7, 32'd2, 33);
    run("divneg",2'b10, OPR, 3'b100, F7M, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run("divu0", 2'b10, OPR, 3'b101, F7M, 32'd55, 32'd0, 32'hFFFFFFFF, 1);
    run("rem0",  2'b10, OPR, 3'b110, F7M, 32'd55, 32'd0, 32'd55, 1);
    run("divovf",2'b10, OPR, 3'b100, F7M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("removf",2'b10, OPR, 3'b110, F7M, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
    issue(2'b10, OPR, 3'b011, F7M, 32'h00010000, 32'h00010000, lat);
    check("hold.lat", 64'(lat), 64'(33));
    check("hold.res", 64'(Result), 64'(1));
    held = Result;
    @(negedge clk);
    ALUOp = 2'b00; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold.stable", 64'(Result), 64'(held));
      check("hold.in_ready", 64'(in_ready), 64'(0));
      check("hold.out_valid", 64'(out_valid), 64'(1));
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    check("pop.in_ready", 64'(in_ready), 64'(1));
    check("pop.no_accept", 64'(out_valid), 64'(0));
    @(negedge clk);
    ALUOp = 2'b10; op = OPR; funct3 = 3'b100; funct7 = F7M; SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort.out_valid", 64'(out_valid), 64'(0));
    check("abort.in_ready", 64'(in_ready), 64'(1));
    check("abort.result", 64'(Result), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    check("abort.no_output", 64'(seen), 64'(0));
    check("abort.idle", 64'(in_ready), 64'(1));
    run("post_rst", 2'b00, OPR, 3'b000, 7'h00, 32'd2, 32'd3, 32'd5, 1);
    run8("x8.mul",   3'b000, 8'h10, 8'h10, 8'h00, 9);
    run8("x8.mulhu", 3'b011, 8'h10, 8'h10, 8'h01, 9);
    run8("x8.div",   3'b100, 8'hF9, 8'h02, 8'hFD, 9);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 Parameter XLEN, default 32, sets the operand and result width in bits; legal values are 8 to 64, powers of two.
REQ-002 Parameter MDU_EN, default 1; when 0, M-extension decode is disabled and those encodings decode as ADD.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 ALUOp  input  2  00 load/store add, 01 branch subtract, 10 R/I-type decode, 11 reserved.
REQ-008 op  input  7  instruction opcode.
REQ-009 funct3  input  3  instruction funct3.
REQ-010 funct7  input  7  instruction funct7.
REQ-011 SrcA, SrcB  input  XLEN each  operands.
REQ-012 out_valid  output  1  Result is valid.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 Result  output  XLEN  registered result.
REQ-015 Zero  output  1  registered flag; high when Result is all zeros.

Function
REQ-016 The block shall decode a 4-bit ALUControl as follows.
- ALUOp=00 gives ADD; ALUOp=01 gives SUB; ALUOp=11 gives ADD.
- ALUOp=10 decodes on funct3: 000 ADD, or SUB when op[5]&funct7[5]; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7[5]; 110 OR; 111 AND.
REQ-017 With ALUOp=10, op[5]=1, funct7=0000001 and MDU_EN=1, the block shall decode funct3 as follows.
- 000 MUL; 011 MULHU; 100 DIV; 101 DIVU; 110 REM; 111 REMU.
- 001 and 010 decode as MUL.
REQ-018 Shift amounts shall use SrcB[$clog2(XLEN)-1:0].
REQ-019 SLT and SLTU shall zero-extend the 1-bit compare result to XLEN.
REQ-020 The FSM states shall be IDLE, MUL, DIV and DONE.
REQ-021 in_ready shall be high only in IDLE.
REQ-022 A request is accepted on an edge where in_valid&in_ready is high; operands and decode are captured at that edge.
REQ-023 Accepting a non-M op shall go IDLE->DONE, with Result and Zero loaded at the same edge (latency 1 cycle).
REQ-024 Accepting MUL or MULHU shall go IDLE->MUL.
- Unsigned shift-add runs one bit per cycle for XLEN cycles into a 2*XLEN accumulator.
- The block then goes to DONE with the low half (MUL) or high half (MULHU).
- Accept-to-out_valid latency is XLEN+1 cycles.
REQ-025 Accepting DIV, DIVU, REM or REMU shall go IDLE->DIV.
- Restoring division on magnitudes (signed ops) runs one bit per cycle for XLEN cycles.
- Sign correction is applied on the DIV->DONE transition: quotient negative if signs differ, remainder takes the dividend sign.
- Latency is XLEN+1 cycles.
REQ-026 Divide by zero shall go IDLE->DONE in 1 cycle: quotient all ones, remainder SrcA.
REQ-027 Signed overflow (SrcA = minimum negative, SrcB = -1) shall go IDLE->DONE in 1 cycle: quotient SrcA, remainder 0.
REQ-028 In DONE, out_valid shall be high and Result and Zero shall hold stable until out_ready is high; then DONE->IDLE.
REQ-029 in_valid shall be ignored outside IDLE, and no new request is accepted on the DONE->IDLE edge.
REQ-030 The iteration counter shall be $clog2(XLEN)+1 bits, load XLEN on accept, and decrement to 0; exit MUL or DIV when it reaches 1.
REQ-031 All arithmetic shall wrap modulo 2^XLEN, with no overflow flag.

Reset
REQ-032 While rst is low: state IDLE, out_valid 0, Result 0, Zero 0, counter 0, internal accumulators 0.
REQ-033 Reset asserted mid-operation shall abort the operation with no output; after release the block is in IDLE with in_ready=1.

Structure
REQ-034 Package alu_pkg shall hold the ALUControl code constants, the ALUOp encodings and the FSM state typedef.
REQ-035 Decode shall live in one combinational sub-module, alu_ctrl_decode (inputs ALUOp, op, funct3, funct7; output ALUControl; parameter MDU_EN).
REQ-036 The datapath, FSM and iterative units shall reside in alu_mdu_seq.

Verification
REQ-037 ALUOp=10, op=0110011, funct3=000, funct7=0100000, SrcA=5, SrcB=7 -> out_valid 1 cycle after accept, Result=0xFFFFFFFE, Zero=0.
REQ-038 ALUOp=10, funct3=101, funct7=0100000, SrcA=0x80000000, SrcB=4 -> Result=0xF8000000; same inputs with funct7=0 -> Result=0x08000000.
REQ-039 MULHU, SrcA=SrcB=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, Result=0xFFFFFFFE; MUL on the same operands -> 0x00000001.
REQ-040 DIV, SrcA=-7, SrcB=2 -> Result=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU with SrcB=0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000 by -1 -> 0x80000000.
REQ-041 Hold out_ready=0 for 5 cycles in DONE -> Result stable and in_ready=0 throughout; pulse rst low at cycle 10 of a DIV -> out_valid stays 0 and in_ready=1 after release.
REQ-042 XLEN=8 build: MUL 0x10*0x10 -> Result=0x00 and Zero=1, with latency 9 cycles.
